organizer_row_sequencer: RTL and testbench

//  Sequences matrix rows through the 8-wide organizer row adder (adder tree + final accumulator).
//  Per row: streams cfg_chunks 8-element chunks from the row buffer, gates org_start and
//  org_outsider4, counts returned tree results, captures the accumulated row sum.

---
 rtl/organizer_row_seq_pkg.sv | 21 ++
 rtl/organizer_row_sequencer_if.sv | 40 ++++
 rtl/organizer_row_seq_watchdog.sv | 31 +++
 rtl/organizer_row_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_organizer_row_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/organizer_row_seq_pkg.sv
// Purpose : shared widths, watchdog default and FSM state type for the organizer row sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package organizer_row_seq_pkg;

  localparam int ELEMENT_WIDTH_DEF = 32;
  localparam int CNT_W_DEF         = 8;
  localparam int ROW_W_DEF         = 10;
  localparam int ADDR_W_DEF        = 16;
  localparam int TIMEOUT_DEF       = 64;

  // One row flows IDLE -> ISSUE -> DRAIN -> HOLD -> (GAP -> ISSUE ...) -> IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/organizer_row_sequencer_if.sv
// Purpose : groups the row-buffer read, organizer control/return and result handshake signals.
// Latency : n/a (wiring only).
// Backpressure: res_valid is held by the master until the slave raises res_ready.
// Ports   : master = sequencer side (drives reads, organizer control, result);
//           slave  = environment side (row buffer + organizer + result consumer).
interface organizer_row_sequencer_if
  import organizer_row_seq_pkg::*;
#(
  parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
  parameter int ROW_W         = ROW_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF
) ();

  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     org_start;
  logic                     org_outsider4;
  logic                     org_exe_finish;
  logic                     org_final_finish;
  logic [ELEMENT_WIDTH-1:0] org_adder_output;
  logic [ELEMENT_WIDTH-1:0] res_data;
  logic [ROW_W-1:0]         res_row;
  logic                     res_valid;
  logic                     res_ready;

  modport master (
    output rd_en, rd_addr, org_start, org_outsider4,
    input  org_exe_finish, org_final_finish, org_adder_output,
    output res_data, res_row, res_valid,
    input  res_ready
  );

  modport slave (
    input  rd_en, rd_addr, org_start, org_outsider4,
    output org_exe_finish, org_final_finish, org_adder_output,
    input  res_data, res_row, res_valid,
    output res_ready
  );

endinterface

// File: rtl/organizer_row_seq_watchdog.sv
// Purpose : clear/enable counter that flags expiry on the TIMEOUT-th enabled cycle.
// Latency : expire is combinational in the TIMEOUT-th consecutive enabled cycle.
// Backpressure: none.
// Ports   : clk, main_reset_n (sync, active low), clear (dominant), enable, expire.
module organizer_row_seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic main_reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!main_reset_n || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  // cnt holds the number of enabled cycles already elapsed, so this fires
  // in the cycle where the count would reach TIMEOUT.
  assign expire = enable && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/organizer_row_sequencer.sv
// Purpose : sequences matrix rows through one organizer row adder and returns one sum per row.
// Latency : row period = cfg_chunks issue + organizer drain + HOLD + 1 GAP cycle (res_ready high).
// Backpressure: result held in HOLD until res_ready; no new row is issued meanwhile.
// Ports   : clk, main_reset_n (sync, active low); go/cfg_chunks/cfg_rows start a job;
//           bus = row-buffer reads, organizer control/returns, result valid/ready;
//           busy, done, err_cfg, err_timeout status (done/err_* are 1-cycle pulses
//           registered one cycle after their triggering event).
module organizer_row_sequencer
  import organizer_row_seq_pkg::*;
#(
  parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int ROW_W         = ROW_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      main_reset_n,
  input  logic                      go,
  input  logic [CNT_W-1:0]          cfg_chunks,
  input  logic [ROW_W-1:0]          cfg_rows,
  organizer_row_sequencer_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err_cfg,
  output logic                      err_timeout
);

  seq_state_t state, state_n;

  logic [CNT_W-1:0]         chunks_q;
  logic [ROW_W-1:0]         rows_q;
  logic [ROW_W-1:0]         row_q;
  logic [CNT_W-1:0]         issue_cnt;
  logic [CNT_W-1:0]         ret_cnt;
  logic [CNT_W-1:0]         ret_cnt_n;
  logic [ADDR_W-1:0]        rd_addr_q;
  logic                     outsider_q;
  logic [ELEMENT_WIDTH-1:0] res_data_q;
  logic [ROW_W-1:0]         res_row_q;
  logic                     res_valid_q;
  logic                     done_q;
  logic                     err_cfg_q;
  logic                     err_timeout_q;

  logic rd_en_c;
  logic org_start_c;
  logic start_job;
  logic cfg_bad;
  logic capture;
  logic accept;
  logic abort;
  logic last_issue;
  logic last_row;
  logic wd_expire;

  assign last_issue = (issue_cnt == chunks_q - CNT_W'(1));
  assign last_row   = (row_q == rows_q - ROW_W'(1));

  // Returns are counted whenever the organizer is running, so a fast
  // organizer may return chunks while later ones are still being issued.
  assign ret_cnt_n = ret_cnt + CNT_W'(bus.org_exe_finish);

  organizer_row_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .main_reset_n (main_reset_n),
    .clear        (state != DRAIN),
    .enable       (state == DRAIN),
    .expire       (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!main_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    rd_en_c     = 1'b0;
    org_start_c = 1'b0;
    start_job   = 1'b0;
    cfg_bad     = 1'b0;
    capture     = 1'b0;
    accept      = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          if ((cfg_chunks != '0) && (cfg_rows != '0)) begin
            start_job = 1'b1;
            state_n   = ISSUE;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end
      ISSUE: begin
        rd_en_c     = 1'b1;
        org_start_c = 1'b1;
        if (last_issue) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        org_start_c = 1'b1;
        // A final pulse arriving before every chunk has returned belongs to a
        // partial sum and is ignored; the last exe pulse may coincide with it.
        if ((ret_cnt_n == chunks_q) && bus.org_final_finish) begin
          capture = 1'b1;
          state_n = HOLD;
        end else if (wd_expire) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          accept  = 1'b1;
          state_n = last_row ? IDLE : GAP;
        end
      end
      GAP: begin
        // org_start low for this cycle re-arms the organizer's first-chunk logic.
        state_n = ISSUE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!main_reset_n) begin
      chunks_q      <= '0;
      rows_q        <= '0;
      row_q         <= '0;
      issue_cnt     <= '0;
      ret_cnt       <= '0;
      rd_addr_q     <= '0;
      outsider_q    <= 1'b0;
      res_data_q    <= '0;
      res_row_q     <= '0;
      res_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      done_q        <= accept && last_row;
      err_cfg_q     <= cfg_bad;
      err_timeout_q <= abort;
      outsider_q    <= rd_en_c;
      issue_cnt     <= rd_en_c ? issue_cnt + CNT_W'(1) : '0;
      ret_cnt       <= org_start_c ? ret_cnt_n : '0;

      if (start_job) begin
        chunks_q  <= cfg_chunks;
        rows_q    <= cfg_rows;
        row_q     <= '0;
        rd_addr_q <= '0;
      end else if (rd_en_c) begin
        // Running chunk base across rows; wraps naturally at 2^ADDR_W.
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
      end

      if (capture) begin
        res_data_q  <= bus.org_adder_output;
        res_row_q   <= row_q;
        res_valid_q <= 1'b1;
      end else if (accept) begin
        res_valid_q <= 1'b0;
      end

      if (accept && !last_row) begin
        row_q <= row_q + ROW_W'(1);
      end
    end
  end

  assign bus.rd_en         = rd_en_c;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.org_start     = org_start_c;
  assign bus.org_outsider4 = outsider_q;
  assign bus.res_data      = res_data_q;
  assign bus.res_row       = res_row_q;
  assign bus.res_valid     = res_valid_q;

  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign err_cfg     = err_cfg_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_organizer_row_sequencer.sv
// Purpose : directed self-checking bench for organizer_row_sequencer with a small organizer model.
// Latency : model returns exe_finish 4 cycles after each rd_en; final pulse per selected mode.
// Backpressure: res_ready driven by the scenario tasks.
module tb_organizer_row_sequencer;
  import organizer_row_seq_pkg::*;

  localparam int TIMEOUT = TIMEOUT_DEF;

  logic       clk = 1'b0;
  logic       main_reset_n;
  logic       go;
  logic [7:0] cfg_chunks;
  logic [9:0] cfg_rows;
  logic       busy, done, err_cfg, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Organizer model mode: 0 final one cycle after last exe, 1 early final after
  // first exe plus final coincident with last exe, 2 final withheld.
  int          mode    = 0;
  int          mchunks = 1;
  logic        pv [0:4];
  logic [15:0] pa [0:4];
  logic [31:0] acc;
  int          mcnt;
  logic        pend;

  always #5 clk = ~clk;

  organizer_row_sequencer_if bus ();

  organizer_row_sequencer dut (
    .clk          (clk),
    .main_reset_n (main_reset_n),
    .go           (go),
    .cfg_chunks   (cfg_chunks),
    .cfg_rows     (cfg_rows),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err_cfg      (err_cfg),
    .err_timeout  (err_timeout)
  );

  // Row-buffer element at chunk address a contributes 100 + a to the row sum.
  always @(posedge clk) begin
    #1;
    if (!main_reset_n) begin
      for (int i = 0; i < 5; i++) begin
        pv[i] = 1'b0;
        pa[i] = '0;
      end
      acc = '0;
      mcnt = 0;
      pend = 1'b0;
      bus.org_exe_finish   = 1'b0;
      bus.org_final_finish = 1'b0;
      bus.org_adder_output = '0;
    end else begin
      for (int i = 4; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = bus.rd_en;
      pa[0] = bus.rd_addr;
      bus.org_exe_finish   = pv[4];
      bus.org_final_finish = 1'b0;
      if (!bus.org_start) begin
        acc = '0;
        mcnt = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          bus.org_final_finish = 1'b1;
          bus.org_adder_output = acc;
          pend = 1'b0;
        end
        if (pv[4]) begin
          mcnt++;
          acc = acc + 32'd100 + 32'(pa[4]);
          if (mode == 1 && mcnt == 1 && mchunks > 1) begin
            bus.org_final_finish = 1'b1;
            bus.org_adder_output = 32'hDEAD_BEEF;
          end
          if (mcnt == mchunks) begin
            if (mode == 0) begin
              pend = 1'b1;
            end else if (mode == 1) begin
              bus.org_final_finish = 1'b1;
              bus.org_adder_output = acc;
            end
          end
        end
      end
    end
  end

  task automatic launch(input logic [7:0] ch, input logic [9:0] rw);
    @(negedge clk);
    cfg_chunks = ch;
    cfg_rows   = rw;
    go         = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic test_reset();
    main_reset_n  = 1'b0;
    go            = 1'b0;
    cfg_chunks    = '0;
    cfg_rows      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    main_reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err_cfg, err_timeout, bus.rd_en, bus.org_start, bus.org_outsider4, bus.res_valid} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000000",
               {busy, done, err_cfg, err_timeout, bus.rd_en, bus.org_start, bus.org_outsider4, bus.res_valid});
    end
    n_checks++;
    if (bus.rd_addr !== 16'd0 || bus.res_data !== 32'd0 || bus.res_row !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_regs: rd_addr=%0d res_data=%0d res_row=%0d required all 0",
               bus.rd_addr, bus.res_data, bus.res_row);
    end
  endtask

  task automatic test_two_rows();
    int naddr = 0, nres = 0, ndone = 0;
    logic prev_rd = 1'b0;
    mode = 0;
    mchunks = 3;
    bus.res_ready = 1'b1;
    launch(8'd3, 10'd2);
    for (int c = 0; c < 60; c++) begin
      if (bus.org_outsider4 !== prev_rd) begin
        n_checks++;
        n_fail++;
        $display("FAIL outsider4_delay: cycle %0d got %b required %b", c, bus.org_outsider4, prev_rd);
      end
      prev_rd = bus.rd_en;
      if (bus.rd_en) begin
        n_checks++;
        if (bus.rd_addr !== 16'(naddr)) begin
          n_fail++;
          $display("FAIL rd_addr_seq: issue %0d got %0d required %0d", naddr, bus.rd_addr, naddr);
        end
        naddr++;
      end
      if (bus.res_valid && bus.res_ready) begin
        n_checks++;
        if (bus.res_data !== 32'(303 + 9 * nres) || bus.res_row !== 10'(nres)) begin
          n_fail++;
          $display("FAIL row_result: got data=%0d row=%0d required data=%0d row=%0d",
                   bus.res_data, bus.res_row, 303 + 9 * nres, nres);
        end
        nres++;
      end
      if (done) ndone++;
      @(negedge clk);
    end
    n_checks++;
    if (naddr != 6 || nres != 2 || ndone != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL two_rows_totals: issues=%0d results=%0d dones=%0d busy=%b required 6 2 1 0",
               naddr, nres, ndone, busy);
    end
  endtask

  task automatic test_hold_backpressure();
    int waited = 0;
    mode = 0;
    mchunks = 1;
    bus.res_ready = 1'b0;
    launch(8'd1, 10'd1);
    while (!bus.res_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!bus.res_valid) begin
      n_fail++;
      $display("FAIL hold_wait_valid: res_valid=%b after %0d cycles required 1", bus.res_valid, waited);
    end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd100 || bus.rd_en !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: cycle %0d valid=%b data=%0d rd_en=%b done=%b required 1 100 0 0",
                 c, bus.res_valid, bus.res_data, bus.rd_en, done);
      end
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.res_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: valid=%b done=%b busy=%b required 0 1 0", bus.res_valid, done, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b required 0", done);
    end
  endtask

  task automatic test_cfg_error();
    logic [7:0] ch [0:1];
    logic [9:0] rw [0:1];
    ch[0] = 8'd0; rw[0] = 10'd1;
    ch[1] = 8'd2; rw[1] = 10'd0;
    for (int k = 0; k < 2; k++) begin
      launch(ch[k], rw[k]);
      n_checks++;
      if (err_cfg !== 1'b1 || busy !== 1'b0 || bus.rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_err_pulse: case %0d err_cfg=%b busy=%b rd_en=%b required 1 0 0",
                 k, err_cfg, busy, bus.rd_en);
      end
      @(negedge clk);
      n_checks++;
      if (err_cfg !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_err_clear: case %0d err_cfg=%b busy=%b required 0 0", k, err_cfg, busy);
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    int waited = 0;
    logic [31:0] got;
    mode = 0;
    mchunks = 4;
    bus.res_ready = 1'b1;
    launch(8'd4, 10'd1);
    @(negedge clk);
    n_checks++;
    if (bus.rd_en !== 1'b1 || bus.rd_addr !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_issue_chunk2: rd_en=%b rd_addr=%0d required 1 1", bus.rd_en, bus.rd_addr);
    end
    main_reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, bus.rd_en, bus.org_start, bus.org_outsider4, bus.res_valid, done} !== 6'b0 ||
        bus.rd_addr !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_row: flags=%b rd_addr=%0d required 000000 0",
               {busy, bus.rd_en, bus.org_start, bus.org_outsider4, bus.res_valid, done}, bus.rd_addr);
    end
    @(negedge clk);
    main_reset_n = 1'b1;
    repeat (6) @(negedge clk);
    mchunks = 2;
    launch(8'd2, 10'd1);
    n_checks++;
    if (bus.rd_en !== 1'b1 || bus.rd_addr !== 16'd0) begin
      n_fail++;
      $display("FAIL restart_addr: rd_en=%b rd_addr=%0d required 1 0", bus.rd_en, bus.rd_addr);
    end
    got = '0;
    while (!done && waited < 40) begin
      if (bus.res_valid) got = bus.res_data;
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (done !== 1'b1 || got !== 32'd201) begin
      n_fail++;
      $display("FAIL restart_result: done=%b data=%0d required 1 201", done, got);
    end
  endtask

  task automatic test_timeout();
    int c = 0, t_drain = -1, t_err = -1;
    logic saw_done = 1'b0;
    mode = 2;
    mchunks = 2;
    bus.res_ready = 1'b1;
    launch(8'd2, 10'd1);
    while (t_err < 0 && c < 200) begin
      if (t_drain < 0 && busy && bus.org_start && !bus.rd_en) t_drain = c;
      if (err_timeout) t_err = c;
      if (done) saw_done = 1'b1;
      if (t_err < 0) begin
        @(negedge clk);
        c++;
      end
    end
    n_checks++;
    if (t_drain < 0 || t_err < 0 || (t_err - t_drain) != TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_latency: drain_at=%0d err_at=%0d got delta=%0d required %0d",
               t_drain, t_err, t_err - t_drain, TIMEOUT);
    end
    n_checks++;
    if (busy !== 1'b0 || bus.org_start !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort: busy=%b org_start=%b res_valid=%b required 0 0 0",
               busy, bus.org_start, bus.res_valid);
    end
    @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse_width: err_timeout=%b required 0", err_timeout);
    end
    repeat (5) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_no_done: saw done=%b required 0", saw_done);
    end
  endtask

  task automatic test_early_final();
    int c = 0, exe_seen = 0, last_exe = -1, t_valid = -1, waited = 0;
    mode = 1;
    mchunks = 3;
    bus.res_ready = 1'b0;
    launch(8'd3, 10'd1);
    while (t_valid < 0 && c < 60) begin
      if (bus.res_valid) begin
        t_valid = c;
      end else begin
        if (bus.org_exe_finish) begin
          exe_seen++;
          last_exe = c;
        end
        @(negedge clk);
        c++;
      end
    end
    n_checks++;
    if (t_valid < 0 || exe_seen != 3 || (t_valid - last_exe) != 1) begin
      n_fail++;
      $display("FAIL early_final_ignored: valid_at=%0d exe_before=%0d last_exe_at=%0d required 3 returns and valid 1 cycle after last",
               t_valid, exe_seen, last_exe);
    end
    n_checks++;
    if (bus.res_data !== 32'd303 || bus.res_row !== 10'd0) begin
      n_fail++;
      $display("FAIL early_final_data: got data=%0d row=%0d required 303 0", bus.res_data, bus.res_row);
    end
    bus.res_ready = 1'b1;
    while (!done && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL early_final_done: done=%b required 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_two_rows();
    test_hold_backpressure();
    test_cfg_error();
    test_reset_mid_issue();
    test_timeout();
    test_early_final();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
